// File: rtl/i2c_burst_master.sv
// Single-clock I2C master: one START / address / N-byte / STOP transaction per Go,
// read or write, with slave ACK checking, NACK abort and per-byte data handshake.
module i2c_burst_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned BC_W      = 3
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            Go,
  input  logic            ReadNotWrite,
  input  logic [6:0]      SlaveAddr,
  input  logic [BC_W-1:0] ByteCount,
  input  logic [7:0]      TxData,
  output logic            TxLoad,
  output logic [7:0]      RxData,
  output logic            RxValid,
  output logic            Busy,
  output logic            Done,
  output logic            AckError,
  output logic            SCL,
  output logic            SDA_oe,
  input  logic            SDA_in
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [1:0]        q, q_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [7:0]        sh, sh_nxt;
  logic [BC_W-1:0]   rem, rem_nxt;
  logic              rnw, rnw_nxt;
  logic              ack_bit, ack_nxt;
  logic              busy_d, busy_d_nxt;
  logic              tx_load_nxt, rx_valid_nxt, busy_nxt, done_nxt, ack_err_nxt;
  logic              scl_nxt, oe_nxt;
  logic [7:0]        rx_data_nxt;
  logic              tick, end_bit, bit_out;

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign end_bit = Busy && tick && (q == 2'd3);
  // On the TxLoad clock the shifter is still loading, so drive straight from TxData.
  assign bit_out = (state == S_WDATA && TxLoad) ? TxData[7] : sh[7];

  always_comb begin
    state_nxt    = state;
    div_nxt      = div_cnt;
    q_nxt        = q;
    bit_nxt      = bit_cnt;
    sh_nxt       = sh;
    rem_nxt      = rem;
    rnw_nxt      = rnw;
    ack_nxt      = ack_bit;
    rx_data_nxt  = RxData;
    rx_valid_nxt = 1'b0;
    busy_nxt     = Busy;
    ack_err_nxt  = AckError;
    busy_d_nxt   = Busy;
    done_nxt     = busy_d & ~Busy;
    scl_nxt      = 1'b1;
    oe_nxt       = 1'b0;

    if (Busy) begin
      div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) q_nxt = q + 2'd1;
    end
    if (Busy && tick && q == 2'd2) begin
      ack_nxt = SDA_in;
      if (state == S_RDATA) sh_nxt = {sh[6:0], SDA_in};
    end
    if (TxLoad) sh_nxt = TxData;

    case (state)
      S_IDLE: if (Go) begin
        state_nxt   = S_START;
        busy_nxt    = 1'b1;
        ack_err_nxt = 1'b0;
        rnw_nxt     = ReadNotWrite;
        sh_nxt      = {SlaveAddr, ReadNotWrite};
        rem_nxt     = (ByteCount > BC_W'(MAX_BYTES)) ? BC_W'(MAX_BYTES) : ByteCount;
        bit_nxt     = '0;
        div_nxt     = '0;
        q_nxt       = '0;
      end
      S_START: if (end_bit) state_nxt = S_ADDR;
      S_ADDR, S_WDATA: if (end_bit) begin
        sh_nxt  = {sh[6:0], 1'b0};
        bit_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = (state == S_ADDR) ? S_AACK : S_WACK;
      end
      S_AACK: if (end_bit) begin
        if (ack_bit) begin
          ack_err_nxt = 1'b1;
          state_nxt   = S_STOP;
        end else if (rem == '0) state_nxt = S_STOP;
        else state_nxt = rnw ? S_RDATA : S_WDATA;
      end
      S_WACK: if (end_bit) begin
        if (ack_bit) begin
          ack_err_nxt = 1'b1;
          state_nxt   = S_STOP;
        end else begin
          if (rem != '0) rem_nxt = rem - BC_W'(1);
          state_nxt = (rem <= BC_W'(1)) ? S_STOP : S_WDATA;
        end
      end
      S_RDATA: if (end_bit) begin
        bit_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_nxt  = sh;
          rx_valid_nxt = 1'b1;
          state_nxt    = S_MACK;
        end
      end
      S_MACK: if (end_bit) begin
        if (rem != '0) rem_nxt = rem - BC_W'(1);
        state_nxt = (rem <= BC_W'(1)) ? S_STOP : S_RDATA;
      end
      S_STOP: if (end_bit) begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        div_nxt   = '0;
        q_nxt     = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Bus levels follow the current quarter, registered one clock later.
    case (state)
      S_START: begin
        scl_nxt = (q != 2'd3);
        oe_nxt  = q[1];
      end
      S_ADDR, S_WDATA: begin
        scl_nxt = (q == 2'd1 || q == 2'd2);
        oe_nxt  = ~bit_out;
      end
      S_AACK, S_WACK, S_RDATA: scl_nxt = (q == 2'd1 || q == 2'd2);
      S_MACK: begin
        scl_nxt = (q == 2'd1 || q == 2'd2);
        oe_nxt  = (rem > BC_W'(1));
      end
      S_STOP: begin
        scl_nxt = (q != 2'd0);
        oe_nxt  = ~q[1];
      end
      default: ;
    endcase

    tx_load_nxt = (state_nxt == S_WDATA) && (state != S_WDATA);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      rem      <= '0;
      rnw      <= 1'b0;
      ack_bit  <= 1'b0;
      busy_d   <= 1'b0;
      TxLoad   <= 1'b0;
      RxData   <= '0;
      RxValid  <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      AckError <= 1'b0;
      SCL      <= 1'b1;
      SDA_oe   <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      q        <= q_nxt;
      bit_cnt  <= bit_nxt;
      sh       <= sh_nxt;
      rem      <= rem_nxt;
      rnw      <= rnw_nxt;
      ack_bit  <= ack_nxt;
      busy_d   <= busy_d_nxt;
      TxLoad   <= tx_load_nxt;
      RxData   <= rx_data_nxt;
      RxValid  <= rx_valid_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
      AckError <= ack_err_nxt;
      SCL      <= scl_nxt;
      SDA_oe   <= oe_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: bus-level slave model, table of transactions,
// plus reset-mid-transfer and back-to-back Go sequences.
module tb_i2c_burst_master;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned BC_W      = 3;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0, rnw = 1'b0;
  logic [6:0] addr = '0;
  logic [BC_W-1:0] cnt = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic tx_load, rx_valid, busy, done, ack_error, scl, sda_oe, sda_line;
  logic slave_pull = 1'b0;

  assign sda_line = ~(sda_oe | slave_pull);
  always #5 clk = ~clk;

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .BC_W(BC_W)) dut (
    .clock(clk), .Reset(rst), .Go(go), .ReadNotWrite(rnw), .SlaveAddr(addr),
    .ByteCount(cnt), .TxData(tx_data), .TxLoad(tx_load), .RxData(rx_data),
    .RxValid(rx_valid), .Busy(busy), .Done(done), .AckError(ack_error),
    .SCL(scl), .SDA_oe(sda_oe), .SDA_in(sda_line)
  );

  int n_vec = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: event counters and the TxData supplier.
  int busy_n = 0, done_n = 0, done_bad = 0, txl_n = 0, tx_base = 0, rx_n = 0, k_tx = 0;
  logic [7:0] rx_log [16];
  logic [3:0][7:0] cur_tx = '0;
  logic b1 = 1'b0, b2 = 1'b0;
  always @(negedge clk) begin
    k_tx = txl_n - tx_base;
    tx_data = (k_tx >= 0 && k_tx < 4) ? cur_tx[k_tx] : 8'h00;
    if (tx_load) txl_n++;
    if (busy) busy_n++;
    if (done) begin
      done_n++;
      if (!(b1 == 1'b0 && b2 == 1'b1)) done_bad++;
    end
    if (rx_valid) begin
      rx_log[rx_n % 16] = rx_data;
      rx_n++;
    end
    b2 = b1;
    b1 = busy;
  end

  // Slave model: watches SCL/SDA, logs written bytes, ACKs/NACKs, serves read bytes.
  int sl_nack_at = -1;
  logic [3:0][7:0] sl_rd = '0;
  int wr_n = 0, mack_n = 0, start_n = 0, stop_n = 0, s_bit = 0, s_byte = 0;
  logic [7:0] wr_log [16];
  logic mack_log [16];
  logic [7:0] s_sh = '0;
  logic scl_prev = 1'b1, sda_prev = 1'b1;
  logic s_active = 1'b0, s_skip = 1'b0, s_reading = 1'b0, s_rnw = 1'b0, s_ackok = 1'b0;
  always @(scl or sda_line) begin
    if (scl && scl_prev && sda_prev && !sda_line) begin
      s_active = 1'b1; s_skip = 1'b1; s_reading = 1'b0;
      s_bit = 0; s_byte = 0; slave_pull = 1'b0; start_n++;
    end else if (scl && scl_prev && !sda_prev && sda_line) begin
      s_active = 1'b0; slave_pull = 1'b0; stop_n++;
    end else if (s_active && scl && !scl_prev) begin
      if (s_bit < 8) s_sh = {s_sh[6:0], sda_line};
      else if (s_reading) begin
        mack_log[mack_n % 16] = sda_line;
        mack_n++;
        s_ackok = !sda_line;
      end
    end else if (s_active && !scl && scl_prev) begin
      if (s_skip) s_skip = 1'b0;
      else begin
        s_bit++;
        if (s_bit == 8) begin
          slave_pull = 1'b0;
          if (!s_reading) begin
            wr_log[wr_n % 16] = s_sh;
            wr_n++;
            s_ackok = (s_byte != sl_nack_at);
            slave_pull = s_ackok;
          end
        end else if (s_bit == 9) begin
          if (s_byte == 0) s_rnw = s_sh[0];
          s_bit = 0;
          s_byte++;
          s_reading = s_rnw;
          slave_pull = 1'b0;
          if (s_reading && s_ackok && s_byte <= 4) slave_pull = ~sl_rd[s_byte-1][7];
        end else if (s_reading && s_byte >= 1 && s_byte <= 4) begin
          slave_pull = ~sl_rd[s_byte-1][7-s_bit];
        end
      end
    end
    scl_prev = scl;
    sda_prev = sda_line;
  end

  typedef struct {
    logic            rnw;
    logic [6:0]      addr;
    logic [2:0]      cnt;
    logic [3:0][7:0] data;
    int              nack_at;
    int              exp_bytes;
    int              exp_busy;
    logic            exp_err;
    logic [7:0]      exp_addr_byte;
    logic            go_mid;
  } vec_t;

  vec_t vecs [7];
  int b_busy, b_done, b_bad, b_txl, b_rx, b_wr, b_mack, b_start, b_stop, gap, t;

  function automatic vec_t mk(logic r, logic [6:0] a, logic [2:0] c, logic [31:0] d,
                              int na, int eb, int ebusy, logic ee, logic [7:0] eab, logic gm);
    vec_t v;
    v.rnw = r; v.addr = a; v.cnt = c; v.data = d; v.nack_at = na; v.exp_bytes = eb;
    v.exp_busy = ebusy; v.exp_err = ee; v.exp_addr_byte = eab; v.go_mid = gm;
    return v;
  endfunction

  task automatic snap();
    b_busy = busy_n; b_done = done_n; b_bad = done_bad; b_txl = txl_n; b_rx = rx_n;
    b_wr = wr_n; b_mack = mack_n; b_start = start_n; b_stop = stop_n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Bus time per transaction = bits * 4 * CLK_DIV clocks, bits = 1 + 9*(1+bytes) + 1.
    vecs[0] = mk(1'b0, 7'h50, 3'd1, 32'h000000A5, -1, 1, 160, 1'b0, 8'hA0, 1'b0);
    vecs[1] = mk(1'b1, 7'h68, 3'd2, 32'h0000F03C, -1, 2, 232, 1'b0, 8'hD1, 1'b0);
    vecs[2] = mk(1'b0, 7'h2A, 3'd3, 32'h00332211,  2, 2, 232, 1'b1, 8'h54, 1'b0);
    vecs[3] = mk(1'b0, 7'h7F, 3'd0, 32'h00000000,  0, 0,  88, 1'b1, 8'hFE, 1'b0);
    vecs[4] = mk(1'b0, 7'h33, 3'd0, 32'h00000000, -1, 0,  88, 1'b0, 8'h66, 1'b0);
    vecs[5] = mk(1'b0, 7'h12, 3'd7, 32'hC4C3C2C1, -1, 4, 376, 1'b0, 8'h24, 1'b1);
    vecs[6] = mk(1'b1, 7'h01, 3'd1, 32'h0000005A, -1, 1, 160, 1'b0, 8'h03, 1'b0);

    repeat (3) @(negedge clk);
    check("rst SCL", int'(scl), 1);
    check("rst SDA_oe", int'(sda_oe), 0);
    check("rst Busy", int'(busy), 0);
    check("rst Done", int'(done), 0);
    check("rst TxLoad", int'(tx_load), 0);
    check("rst RxValid", int'(rx_valid), 0);
    check("rst AckError", int'(ack_error), 0);
    check("rst RxData", int'(rx_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      snap();
      cur_tx = vecs[i].data; sl_rd = vecs[i].data; sl_nack_at = vecs[i].nack_at;
      tx_base = txl_n;
      rnw = vecs[i].rnw; addr = vecs[i].addr; cnt = vecs[i].cnt; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check($sformatf("v%0d busy after go", i), int'(busy), 1);
      check($sformatf("v%0d ackerr cleared", i), int'(ack_error), 0);
      for (int c = 0; c < 3000 && done_n == b_done; c++) begin
        @(negedge clk);
        go = vecs[i].go_mid && (c == 100);
      end
      go = 1'b0;
      check($sformatf("v%0d done count", i), done_n - b_done, 1);
      check($sformatf("v%0d done timing", i), done_bad - b_bad, 0);
      check($sformatf("v%0d busy clocks", i), busy_n - b_busy, vecs[i].exp_busy);
      check($sformatf("v%0d AckError", i), int'(ack_error), int'(vecs[i].exp_err));
      check($sformatf("v%0d TxLoad pulses", i), txl_n - b_txl,
            vecs[i].rnw ? 0 : vecs[i].exp_bytes);
      check($sformatf("v%0d bytes seen by slave", i), wr_n - b_wr,
            vecs[i].rnw ? 1 : 1 + vecs[i].exp_bytes);
      check($sformatf("v%0d addr byte", i), int'(wr_log[b_wr % 16]), int'(vecs[i].exp_addr_byte));
      check($sformatf("v%0d RxValid pulses", i), rx_n - b_rx,
            vecs[i].rnw ? vecs[i].exp_bytes : 0);
      for (int j = 0; j < vecs[i].exp_bytes; j++) begin
        if (vecs[i].rnw) begin
          check($sformatf("v%0d rx byte %0d", i, j), int'(rx_log[(b_rx + j) % 16]),
                int'(vecs[i].data[j]));
          check($sformatf("v%0d master ack %0d", i, j), int'(mack_log[(b_mack + j) % 16]),
                (j == vecs[i].exp_bytes - 1) ? 1 : 0);
        end else begin
          check($sformatf("v%0d wr byte %0d", i, j), int'(wr_log[(b_wr + 1 + j) % 16]),
                int'(vecs[i].data[j]));
        end
      end
      repeat (12) @(negedge clk);
      check($sformatf("v%0d starts", i), start_n - b_start, 1);
      check($sformatf("v%0d stops", i), stop_n - b_stop, 1);
      check($sformatf("v%0d idle after", i), int'(busy), 0);
    end

    // AckError from a NACK must still be held while idle.
    snap();
    sl_nack_at = 0; rnw = 1'b0; addr = 7'h0F; cnt = 3'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 3000 && done_n == b_done; c++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("ackerr held idle", int'(ack_error), 1);

    // Reset in the middle of an address bit.
    snap();
    sl_nack_at = -1; rnw = 1'b0; addr = 7'h55; cnt = 3'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (20) @(negedge clk);
    check("mid busy before reset", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst SCL", int'(scl), 1);
    check("mid rst SDA_oe", int'(sda_oe), 0);
    check("mid rst Busy", int'(busy), 0);
    check("mid rst Done", int'(done), 0);
    check("mid rst AckError", int'(ack_error), 0);
    check("mid rst RxData", int'(rx_data), 0);
    repeat (10) @(negedge clk);
    check("mid rst no Done", done_n - b_done, 0);

    // Go held high: two transactions with one idle clock between them.
    snap();
    gap = 0; t = 0;
    sl_nack_at = -1; rnw = 1'b0; addr = 7'h33; cnt = 3'd0; go = 1'b1;
    @(negedge clk);
    while (busy && t < 500) begin @(negedge clk); t++; end
    while (!busy && gap < 10) begin @(negedge clk); gap++; end
    go = 1'b0;
    check("b2b idle gap", gap, 1);
    for (int c = 0; c < 3000 && done_n - b_done < 2; c++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("b2b done count", done_n - b_done, 2);
    check("b2b starts", start_n - b_start, 2);
    check("b2b busy clocks", busy_n - b_busy, 176);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
